ser2par_rx: RTL and testbench

SER2PAR_RX -- requirements
Module: ser2par_rx

---
 rtl/ser2par_rx.sv | 105 ++++++++++
 tb/tb_ser2par_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ser2par_rx.sv
// Serial-to-parallel receiver: start bit, WIDTH data bits LSB-first, stop bit,
// sampled on clk_en edges, with a valid/ready output handshake.
module ser2par_rx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             d_in,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;

  // Next-state logic: the handshake runs every cycle, the frame FSM only on clk_en.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;

    if (valid_q && ready) valid_d = 1'b0;

    if (clk_en) begin
      unique case (state_q)
        IDLE: begin
          if (!d_in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = {d_in, shift_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (d_in) begin
            // A word consumed on this same edge frees the slot for the new one.
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ser2par_rx.sv
// Directed self-checking bench for ser2par_rx (WIDTH=8).
module tb_ser2par_rx;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic       d_in;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int checks;
  int failures;

  ser2par_rx #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .d_in      (d_in),
    .ready     (ready),
    .data      (data),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full frame at clk_en=1; ready is switched to rdy_stop just before the stop sample.
  task automatic send_frame(input logic [7:0] w, input logic stop_bit, input logic rdy_stop);
    clk_en = 1'b1;
    d_in   = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      d_in = w[i];
      tick();
    end
    ready = rdy_stop;
    d_in  = stop_bit;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1; d_in = 1'b1; ready = 1'b1;
    tick();
    checks++;
    if ({data, valid, busy, frame_err, overrun} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000", {data, valid, busy, frame_err, overrun});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    send_frame(8'hCA, 1'b1, 1'b1);
    checks++;
    if (data !== 8'hCA) begin failures++; $display("FAIL basic_data got=%h exp=ca", data); end
    checks++;
    if (valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", valid); end
    checks++;
    if (frame_err !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_flags got fe=%b ov=%b busy=%b exp=0 0 0", frame_err, overrun, busy);
    end
    d_in = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL basic_valid_one_cycle got=%b exp=0", valid); end
  endtask

  task automatic test_slow_enable();
    logic [9:0] bits;
    int busy_cnt;
    bits = {1'b1, 8'hCA, 1'b0};
    busy_cnt = 0;
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 2; k++) begin
        clk_en = 1'b0;
        d_in   = ~bits[i];
        tick();
      end
      clk_en = 1'b1;
      d_in   = bits[i];
      tick();
      if (busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (data !== 8'hCA || valid !== 1'b1) begin
      failures++;
      $display("FAIL slow_word got data=%h valid=%b exp=ca 1", data, valid);
    end
    checks++;
    if (busy_cnt != 9) begin failures++; $display("FAIL slow_busy_samples got=%0d exp=9", busy_cnt); end
    clk_en = 1'b0;
    d_in   = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL slow_ready_while_disabled got=%b exp=0", valid); end
    clk_en = 1'b1;
  endtask

  task automatic test_overrun();
    ready = 1'b0;
    send_frame(8'h55, 1'b1, 1'b0);
    checks++;
    if (data !== 8'h55 || valid !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_first got data=%h valid=%b ov=%b exp=55 1 0", data, valid, overrun);
    end
    send_frame(8'hA3, 1'b1, 1'b0);
    checks++;
    if (data !== 8'h55 || valid !== 1'b1 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_second got data=%h valid=%b ov=%b exp=55 1 1", data, valid, overrun);
    end
    ready = 1'b1;
    d_in  = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_drain got valid=%b ov=%b exp=0 1", valid, overrun);
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 1'b1);
    checks++;
    if (frame_err !== 1'b1 || valid !== 1'b0 || data !== 8'h55) begin
      failures++;
      $display("FAIL ferr_stop got fe=%b valid=%b data=%h exp=1 0 55", frame_err, valid, data);
    end
    d_in = 1'b1;
    tick();
    checks++;
    if (frame_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ferr_after got fe=%b busy=%b exp=0 0", frame_err, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL ferr_idle got busy=%b valid=%b exp=0 0", busy, valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w;
    w = 8'h81;
    d_in = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      d_in = w[i];
      tick();
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data, valid, busy, frame_err, overrun} !== 12'h000) begin
      failures++;
      $display("FAIL mid_async_reset got=%h exp=000", {data, valid, busy, frame_err, overrun});
    end
    #1;
    rst_n = 1'b1;
    d_in  = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_wait_start got=%b exp=0", busy); end
    send_frame(8'h81, 1'b1, 1'b1);
    checks++;
    if (data !== 8'h81 || valid !== 1'b1 || overrun !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_next_frame got data=%h valid=%b ov=%b fe=%b exp=81 1 0 0",
               data, valid, overrun, frame_err);
    end
    d_in = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    ready = 1'b0;
    send_frame(8'hF0, 1'b1, 1'b0);
    checks++;
    if (data !== 8'hF0 || valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first got data=%h valid=%b exp=f0 1", data, valid);
    end
    send_frame(8'h0F, 1'b1, 1'b1);
    checks++;
    if (data !== 8'h0F || valid !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_same_edge got data=%h valid=%b ov=%b exp=0f 1 0", data, valid, overrun);
    end
    d_in = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0 || data !== 8'h0F) begin
      failures++;
      $display("FAIL b2b_drain got valid=%b data=%h exp=0 0f", valid, data);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_slow_enable();
    test_overrun();
    test_frame_err();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
